// File: rtl/qsys_led_st_pkg.sv
// qsys_led_st_pkg: shared state type and round-robin pick for the LED stream arbiter
package qsys_led_st_pkg;
   typedef enum logic {IDLE, LOCKED} state_t;
   localparam int MAX_CH = 8;
   localparam int MAX_IW = $clog2(MAX_CH);
   // First requester at or after ptr (modulo n) with valid set; 0 when none is valid.
   function automatic int rr_pick(input logic [MAX_CH-1:0] valid, input int ptr, input int n);
      int idx;
      rr_pick = 0;
      for (int k = MAX_CH - 1; k >= 0; k--) begin
         idx = (ptr + k) % n;
         if (k < n && valid[idx[MAX_IW-1:0]]) rr_pick = idx;
      end
   endfunction
endpackage

// File: rtl/qsys_led_st_out_reg.sv
// qsys_led_st_out_reg: one-entry registered Avalon-ST output stage with ready/valid handshake
module qsys_led_st_out_reg #(
   parameter int DATA_W = 8,
   parameter int CH_W   = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic [DATA_W-1:0] d_data,
   input  logic [CH_W-1:0]   d_channel,
   input  logic              d_sop,
   input  logic              d_eop,
   input  logic              out_ready,
   output logic              accept_ok,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [CH_W-1:0]   out_channel,
   output logic              out_startofpacket,
   output logic              out_endofpacket
);
   assign accept_ok = !out_valid || out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid         <= 1'b0;
         out_data          <= '0;
         out_channel       <= '0;
         out_startofpacket <= 1'b0;
         out_endofpacket   <= 1'b0;
      end else begin
         out_valid <= load || (out_valid && !out_ready);
         if (load) begin
            out_data          <= d_data;
            out_channel       <= d_channel;
            out_startofpacket <= d_sop;
            out_endofpacket   <= d_eop;
         end
      end
   end
endmodule

// File: rtl/qsys_led_st_channel_arbiter.sv
// qsys_led_st_channel_arbiter: packet-atomic round-robin arbiter tagging each packet with its source channel
module qsys_led_st_channel_arbiter
   import qsys_led_st_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int DATA_W    = 8,
   parameter int CH_W      = 8,
   parameter int STALL_TMO = 256
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [NUM_CH-1:0]        in_startofpacket,
   input  logic [NUM_CH-1:0]        in_endofpacket,
   output logic [NUM_CH-1:0]        in_ready,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [CH_W-1:0]          out_channel,
   output logic                     out_startofpacket,
   output logic                     out_endofpacket,
   output logic                     abort_pulse,
   output logic [CH_W-1:0]          abort_ch
);
   localparam int GW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int SW = STALL_TMO > 1 ? $clog2(STALL_TMO) : 1;

   state_t          state, state_d;
   logic [GW-1:0]   grant, grant_d, rr_ptr, rr_ptr_d, ptr_nxt, pick;
   logic [SW-1:0]   stall_cnt, stall_d;
   logic            abort_d, accept_ok, accept, gv, timeout;

   assign pick     = GW'(rr_pick(MAX_CH'(in_valid), int'(rr_ptr), NUM_CH));
   assign ptr_nxt  = (grant == GW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
   assign gv       = in_valid[grant];
   assign in_ready = (state == LOCKED && accept_ok) ? NUM_CH'(1) << grant : '0;
   assign accept   = gv && in_ready[grant];
   // Only cycles where the granted source has nothing to offer count as stall.
   assign timeout  = STALL_TMO != 0 && !gv && stall_cnt == SW'(STALL_TMO - 1);

   always_comb begin
      state_d  = state;
      grant_d  = grant;
      rr_ptr_d = rr_ptr;
      stall_d  = stall_cnt;
      abort_d  = 1'b0;
      if (state == IDLE) begin
         if (|in_valid) begin
            state_d = LOCKED;
            grant_d = pick;
            stall_d = '0;
         end
      end else if (accept) begin
         stall_d  = '0;
         state_d  = in_endofpacket[grant] ? IDLE : LOCKED;
         rr_ptr_d = in_endofpacket[grant] ? ptr_nxt : rr_ptr;
      end else if (timeout) begin
         state_d  = IDLE;
         rr_ptr_d = ptr_nxt;
         abort_d  = 1'b1;
      end else if (!gv) begin
         stall_d = stall_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         grant       <= '0;
         rr_ptr      <= '0;
         stall_cnt   <= '0;
         abort_pulse <= 1'b0;
         abort_ch    <= '0;
      end else begin
         state       <= state_d;
         grant       <= grant_d;
         rr_ptr      <= rr_ptr_d;
         stall_cnt   <= stall_d;
         abort_pulse <= abort_d;
         if (abort_d) abort_ch <= CH_W'(grant);
      end
   end

   qsys_led_st_out_reg #(
      .DATA_W (DATA_W),
      .CH_W   (CH_W)
   ) u_out_reg (
      .clk               (clk),
      .reset_n           (reset_n),
      .load              (accept),
      .d_data            (in_data[grant*DATA_W +: DATA_W]),
      .d_channel         (CH_W'(grant)),
      .d_sop             (in_startofpacket[grant]),
      .d_eop             (in_endofpacket[grant]),
      .out_ready         (out_ready),
      .accept_ok         (accept_ok),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_channel       (out_channel),
      .out_startofpacket (out_startofpacket),
      .out_endofpacket   (out_endofpacket)
   );
endmodule

// File: tb/tb_qsys_led_st_channel_arbiter.sv
// tb_qsys_led_st_channel_arbiter: directed scoreboard bench for the LED stream channel arbiter
module tb_qsys_led_st_channel_arbiter;
   import qsys_led_st_pkg::*;
   localparam int N = 4;
   typedef struct packed {logic [7:0] data; logic sop; logic eop; logic [7:0] ch;} beat_t;

   logic clk = 1'b0, reset_n = 1'b0, out_ready = 1'b1;
   logic [N-1:0] in_valid = '0, in_sop = '0, in_eop = '0, in_ready, fire = '0;
   logic [N*8-1:0] in_data = '0;
   logic out_valid, out_sop, out_eop, abort_pulse;
   logic [7:0] out_data, out_channel, abort_ch, last_abort_ch = 8'hff;
   logic [9:0] src_q [N][$];
   beat_t exp_q[$];
   int n_chk = 0, n_pass = 0, cyc = 0, abort_cnt = 0, t55 = -1, t_abort = -1;

   qsys_led_st_channel_arbiter #(
      .NUM_CH    (N),
      .DATA_W    (8),
      .CH_W      (8),
      .STALL_TMO (8)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .in_valid          (in_valid),
      .in_data           (in_data),
      .in_startofpacket  (in_sop),
      .in_endofpacket    (in_eop),
      .in_ready          (in_ready),
      .out_ready         (out_ready),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_channel       (out_channel),
      .out_startofpacket (out_sop),
      .out_endofpacket   (out_eop),
      .abort_pulse       (abort_pulse),
      .abort_ch          (abort_ch)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic src(input int r, input logic [7:0] d, input logic s, input logic e);
      src_q[r].push_back({d, s, e});
   endtask

   task automatic exp_b(input logic [7:0] d, input logic s, input logic e, input logic [7:0] c);
      exp_q.push_back(beat_t'({d, s, e, c}));
   endtask

   function automatic bit idle_src();
      for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic check_reset(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 0);
      check({tag, "_out_data"}, 32'(out_data), 0);
      check({tag, "_out_channel"}, 32'(out_channel), 0);
      check({tag, "_out_sop"}, 32'(out_sop), 0);
      check({tag, "_out_eop"}, 32'(out_eop), 0);
      check({tag, "_abort_pulse"}, 32'(abort_pulse), 0);
      check({tag, "_abort_ch"}, 32'(abort_ch), 0);
      check({tag, "_in_ready"}, 32'(in_ready), 0);
   endtask

   task automatic drain(input string name);
      int k = 0;
      while (k < 200 && !(exp_q.size() == 0 && idle_src() && !out_valid)) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(k < 200), 1);
      @(negedge clk);
      #3;
   endtask

   // Source models: present the head of each queue, retire it once the handshake fired.
   initial forever begin
      logic [9:0] b;
      @(negedge clk);
      for (int i = 0; i < N; i++) if (fire[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      for (int i = 0; i < N; i++) begin
         b = src_q[i].size() != 0 ? src_q[i][0] : '0;
         in_valid[i] = src_q[i].size() != 0;
         {in_data[i*8 +: 8], in_sop[i], in_eop[i]} = b;
      end
      #1;
      fire = in_valid & in_ready;
   end

   initial forever begin
      beat_t e;
      @(negedge clk);
      #2;
      if (abort_pulse) begin
         abort_cnt++;
         t_abort = cyc;
         last_abort_ch = abort_ch;
      end
      check("in_ready_onehot0", 32'($onehot0(in_ready)), 1);
      if (out_valid && !out_ready) check("in_ready_backpressure", 32'(in_ready), 0);
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) check("beat_unexpected", 32'(exp_q.size()), 1);
         else begin
            e = exp_q.pop_front();
            check("beat", 32'({out_data, out_sop, out_eop, out_channel}), 32'(e));
            if (out_data == 8'h55) t55 = cyc;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      bit found;
      repeat (3) @(negedge clk);
      check_reset("reset");
      reset_n = 1'b1;
      @(negedge clk);
      #3;
      // single request from req 2
      src(2, 8'hA1, 1, 0); src(2, 8'hA2, 0, 0); src(2, 8'hA3, 0, 1);
      exp_b(8'hA1, 1, 0, 2); exp_b(8'hA2, 0, 0, 2); exp_b(8'hA3, 0, 1, 2);
      @(negedge clk);
      @(posedge clk); #1 check("latency_c1", 32'(out_valid), 0);
      @(posedge clk); #1 check("latency_c2", 32'(out_valid), 1);
      drain("drain_single");
      check("rr_ptr_after_single", 32'(dut.rr_ptr), 3);
      // fairness from rr_ptr=0
      reset_n = 1'b0;
      @(negedge clk); #3 reset_n = 1'b1;
      @(negedge clk); #3;
      src(0, 8'h10, 1, 0); src(0, 8'h11, 0, 1); src(0, 8'h12, 1, 0); src(0, 8'h13, 0, 1);
      src(1, 8'h20, 1, 0); src(1, 8'h21, 0, 1);
      src(3, 8'h30, 1, 0); src(3, 8'h31, 0, 1);
      exp_b(8'h10, 1, 0, 0); exp_b(8'h11, 0, 1, 0);
      exp_b(8'h20, 1, 0, 1); exp_b(8'h21, 0, 1, 1);
      exp_b(8'h30, 1, 0, 3); exp_b(8'h31, 0, 1, 3);
      exp_b(8'h12, 1, 0, 0); exp_b(8'h13, 0, 1, 0);
      drain("drain_fair");
      check("rr_ptr_after_fair", 32'(dut.rr_ptr), 1);
      // backpressure on req 1
      src(1, 8'h40, 1, 0); src(1, 8'h41, 0, 0); src(1, 8'h42, 0, 0); src(1, 8'h43, 0, 1);
      exp_b(8'h40, 1, 0, 1); exp_b(8'h41, 0, 0, 1); exp_b(8'h42, 0, 0, 1); exp_b(8'h43, 0, 1, 1);
      k = 0;
      do begin @(negedge clk); k++; end while (!out_valid && k < 50);
      check("bp_first_valid", 32'(out_valid), 1);
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      out_ready = 1'b1;
      #3;
      drain("drain_bp");
      check("bp_no_abort", 32'(abort_cnt), 0);
      // watchdog: req 0 stalls after its SOP, req 1 waits
      src(0, 8'h55, 1, 0);
      src(1, 8'h60, 1, 0); src(1, 8'h61, 0, 1);
      exp_b(8'h55, 1, 0, 0); exp_b(8'h60, 1, 0, 1); exp_b(8'h61, 0, 1, 1);
      drain("drain_wdog");
      check("wdog_abort_count", 32'(abort_cnt), 1);
      check("wdog_abort_delay", 32'(t_abort - t55), 8);
      check("wdog_abort_ch", 32'(last_abort_ch), 0);
      // EOP accept coinciding with a drain, req 0 waiting
      src(3, 8'h70, 1, 0); src(3, 8'h71, 0, 1); src(0, 8'h80, 1, 1);
      exp_b(8'h70, 1, 0, 3); exp_b(8'h71, 0, 1, 3); exp_b(8'h80, 1, 1, 0);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         #3;
         found = in_valid[3] && in_ready[3] && in_eop[3] && out_valid && out_ready;
      end
      check("simul_seen", 32'(found), 1);
      @(posedge clk); #1;
      check("simul_out_valid", 32'(out_valid), 1);
      check("simul_out_data", 32'(out_data), 32'h71);
      check("simul_state_idle", 32'(dut.state == IDLE), 1);
      @(posedge clk); #1;
      check("simul_state_locked", 32'(dut.state == LOCKED), 1);
      check("simul_grant_wrap", 32'(dut.grant), 0);
      drain("drain_simul");
      // reset in the middle of a 5-beat packet from req 1
      src(1, 8'h90, 1, 0); src(1, 8'h91, 0, 0); src(1, 8'h92, 0, 0); src(1, 8'h93, 0, 0); src(1, 8'h94, 0, 1);
      exp_b(8'h90, 1, 0, 1);
      k = 0;
      do begin @(negedge clk); k++; end while (!(out_valid && out_data == 8'h91) && k < 50);
      check("rst_mid_seen", 32'(out_data), 32'h91);
      reset_n = 1'b0;
      #3;
      check_reset("rst_mid");
      for (int i = 0; i < N; i++) src_q[i].delete();
      check("rst_mid_consumed", 32'(exp_q.size()), 0);
      exp_q.delete();
      @(negedge clk); #3 reset_n = 1'b1;
      src(0, 8'hB0, 1, 1);
      src(1, 8'hC0, 1, 0); src(1, 8'hC1, 0, 1);
      exp_b(8'hB0, 1, 1, 0); exp_b(8'hC0, 1, 0, 1); exp_b(8'hC1, 0, 1, 1);
      drain("drain_after_reset");
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
